// File: rtl/pll_serial_loader_if.sv
// Request/status bundle between a PLL image source (master) and the serial loader (slave).
interface pll_serial_loader_if #(
  parameter int NUM_REGS  = 8,
  parameter int REG_WIDTH = 32
);
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_REGS*REG_WIDTH-1:0] reg_data;
  logic                          start;
  logic                          start_one;
  logic [SEL_W-1:0]              reg_sel;
  logic                          pll_clk;
  logic                          writeData;
  logic                          loadEnable;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    output reg_data, start, start_one, reg_sel,
    input  pll_clk, writeData, loadEnable, busy, done, err
  );

  modport slave (
    input  reg_data, start, start_one, reg_sel,
    output pll_clk, writeData, loadEnable, busy, done, err
  );
endinterface

// File: rtl/pll_serial_loader.sv
// Serial programmer for a PLL register image: words shifted MSB first, highest index first,
// each followed by a loadEnable strobe. Define PLL_AUTO_INIT_EN to program the image once after reset.
module pll_serial_loader #(
  parameter int NUM_REGS  = 8,
  parameter int REG_WIDTH = 32,
  parameter int CLK_DIV   = 4,
  parameter int LE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pll_serial_loader_if.slave   bus
);
  localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int BIT_W   = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
  localparam int MAX_CNT = (CLK_DIV > LE_CYCLES) ? CLK_DIV : LE_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LE_LOAD   = CNT_W'(LE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(REG_WIDTH - 1);
  localparam logic [SEL_W-1:0] LAST_WORD = SEL_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LOW,
    SHIFT_HIGH,
    LATCH,
    GAP
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [SEL_W-1:0]       word_idx_reg, word_idx_next;
  logic                   single_reg, single_next;
  logic [REG_WIDTH-1:0]   shift_reg, shift_next;
  logic                   pll_clk_reg, pll_clk_next;
  logic                   write_data_reg, write_data_next;
  logic                   load_enable_reg, load_enable_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   err_reg, err_next;
  logic                   snap_load;
  logic                   sel_ok;
  logic                   start_eff;

  logic [REG_WIDTH-1:0]   words [NUM_REGS];
  logic [REG_WIDTH-1:0]   snap_reg [NUM_REGS];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_words
      assign words[gi] = bus.reg_data[gi*REG_WIDTH +: REG_WIDTH];
    end

    // When NUM_REGS fills the index range every reg_sel value is a valid word.
    if (NUM_REGS == (1 << SEL_W)) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_partial
      assign sel_ok = (bus.reg_sel < LAST_WORD + 1'b1);
    end
  endgenerate

`ifdef PLL_AUTO_INIT_EN
  logic auto_pending_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_pending_reg <= 1'b1;
    end else begin
      auto_pending_reg <= 1'b0;
    end
  end

  assign start_eff = bus.start | auto_pending_reg;
`else
  assign start_eff = bus.start;
`endif

  // Image snapshot decouples the transfer from reg_data changes while busy.
  always_ff @(posedge clk) begin
    if (snap_load) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snap_reg[i] <= words[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bit_cnt_reg     <= '0;
      word_idx_reg    <= '0;
      single_reg      <= 1'b0;
      shift_reg       <= '0;
      pll_clk_reg     <= 1'b0;
      write_data_reg  <= 1'b0;
      load_enable_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      word_idx_reg    <= word_idx_next;
      single_reg      <= single_next;
      shift_reg       <= shift_next;
      pll_clk_reg     <= pll_clk_next;
      write_data_reg  <= write_data_next;
      load_enable_reg <= load_enable_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_idx_next = word_idx_reg;
    single_next   = single_reg;
    shift_next    = shift_reg;
    snap_load     = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_eff) begin
          snap_load     = 1'b1;
          shift_next    = words[NUM_REGS-1];
          word_idx_next = LAST_WORD;
          single_next   = 1'b0;
          bit_cnt_next  = BIT_LOAD;
          cnt_next      = DIV_LOAD;
          state_next    = SHIFT_LOW;
        end else if (bus.start_one) begin
          if (sel_ok) begin
            shift_next    = words[bus.reg_sel];
            word_idx_next = bus.reg_sel;
            single_next   = 1'b1;
            bit_cnt_next  = BIT_LOAD;
            cnt_next      = DIV_LOAD;
            state_next    = SHIFT_LOW;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      SHIFT_LOW: begin
        if (cnt_reg == '0) begin
          cnt_next   = DIV_LOAD;
          state_next = SHIFT_HIGH;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      SHIFT_HIGH: begin
        if (cnt_reg == '0) begin
          if (bit_cnt_reg == '0) begin
            cnt_next   = LE_LOAD;
            state_next = LATCH;
          end else begin
            shift_next   = shift_reg << 1;
            bit_cnt_next = bit_cnt_reg - 1'b1;
            cnt_next     = DIV_LOAD;
            state_next   = SHIFT_LOW;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      LATCH: begin
        if (cnt_reg == '0) begin
          cnt_next   = DIV_LOAD;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      GAP: begin
        if (cnt_reg == '0) begin
          if (single_reg || (word_idx_reg == '0)) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            word_idx_next = word_idx_reg - 1'b1;
            shift_next    = snap_reg[word_idx_next];
            bit_cnt_next  = BIT_LOAD;
            cnt_next      = DIV_LOAD;
            state_next    = SHIFT_LOW;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered from the next state so the PLL pins never glitch.
    pll_clk_next     = (state_next == SHIFT_HIGH);
    write_data_next  = ((state_next == SHIFT_LOW) || (state_next == SHIFT_HIGH))
                       ? shift_next[REG_WIDTH-1] : 1'b0;
    load_enable_next = (state_next == LATCH);
    busy_next        = (state_next != IDLE);
  end

  assign bus.pll_clk    = pll_clk_reg;
  assign bus.writeData  = write_data_reg;
  assign bus.loadEnable = load_enable_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_pll_serial_loader.sv
// Directed bench for pll_serial_loader: serial bits scored against a queue of expected bits.
module tb_pll_serial_loader;
  localparam int NR       = 8;
  localparam int RW       = 32;
  localparam int CD       = 4;
  localparam int LE       = 8;
  localparam int WORD_CYC = 2*CD*RW + LE + CD;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pll_serial_loader_if #(.NUM_REGS(NR), .REG_WIDTH(RW)) bus ();
  pll_serial_loader_if #(.NUM_REGS(6),  .REG_WIDTH(RW)) bus6 ();

  pll_serial_loader #(.NUM_REGS(NR), .REG_WIDTH(RW), .CLK_DIV(CD), .LE_CYCLES(LE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  pll_serial_loader #(.NUM_REGS(6), .REG_WIDTH(RW), .CLK_DIV(CD), .LE_CYCLES(LE)) dut6 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus6)
  );

  int compared   = 0;
  int mismatched = 0;
  bit exp_bits[$];
  int le_pulses  = 0;
  int le_len     = 0;
  int done_cnt   = 0;
  int rises      = 0;
  logic prev_clk, prev_wd, prev_le;
  logic [RW-1:0] image [NR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_image();
    for (int k = 0; k < NR; k++) bus.reg_data[k*RW +: RW] = image[k];
  endtask

  task automatic push_word(input logic [RW-1:0] w);
    for (int b = RW-1; b >= 0; b--) exp_bits.push_back(w[b]);
  endtask

  task automatic push_full();
    for (int w = NR-1; w >= 0; w--) push_word(image[w]);
  endtask

  task automatic pulse(input logic s, input logic s1, input logic [2:0] sel);
    @(negedge clk);
    bus.start = s; bus.start_one = s1; bus.reg_sel = sel;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.start_one = 1'b0;
    $display("pulse start=%0b start_one=%0b reg_sel=%0d busy=%0b", s, s1, sel, bus.busy);
  endtask

  task automatic wait_done(output int n);
    bit seen = 0;
    n = 0;
    while (n < 5000 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) seen = 1;
    end
    $display("done after %0d cycles, bits left %0d", n, exp_bits.size());
  endtask

  // Scoreboard monitor: one expected bit per pll_clk rising edge, plus pin invariants.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_clk = 1'b0; prev_wd = 1'b0; prev_le = 1'b0; le_len = 0;
    end else begin
      if (bus.pll_clk && !prev_clk) begin
        rises++;
        if (exp_bits.size() == 0) begin
          check("sb_unexpected_bit", 32'(rises), 32'h0);
        end else begin
          check("sb_bit", 32'(bus.writeData), 32'(exp_bits.pop_front()));
        end
      end
      if (bus.writeData !== prev_wd) check("wd_change_clk_low", 32'(bus.pll_clk), 32'h0);
      if (bus.loadEnable) begin
        le_len++;
        check("le_clk_low", 32'(bus.pll_clk), 32'h0);
      end
      if (!bus.loadEnable && prev_le) begin
        le_pulses++;
        check("le_len", 32'(le_len), 32'(LE));
        le_len = 0;
      end
      if (bus.done) done_cnt++;
      prev_clk = bus.pll_clk; prev_wd = bus.writeData; prev_le = bus.loadEnable;
    end
  end

  initial begin
    int n;
    int le0;
    int r0;
    int d0;
    bus.start = 0; bus.start_one = 0; bus.reg_sel = '0;
    bus6.start = 0; bus6.start_one = 0; bus6.reg_sel = '0; bus6.reg_data = '0;
    for (int k = 0; k < NR; k++) image[k] = 32'(k);
    drive_image();

    repeat (3) @(posedge clk); #1;
    check("reset_outputs", {26'h0, bus.pll_clk, bus.writeData, bus.loadEnable,
                            bus.busy, bus.done, bus.err}, 32'h0);

`ifdef PLL_AUTO_INIT_EN
    push_full();
    le0 = le_pulses;
    @(negedge clk); reset_n = 1'b1;
    wait_done(n);
    check("auto_init_latency", 32'(n), 32'(NR*WORD_CYC + 1));
    check("auto_init_le", 32'(le_pulses - le0), 32'(NR));
    check("auto_init_bits_left", 32'(exp_bits.size()), 32'h0);
`else
    @(negedge clk); reset_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("no_auto_init", {30'h0, bus.busy, bus.pll_clk}, 32'h0);
    check("no_auto_init_le", 32'(le_pulses), 32'h0);
`endif

    // Full image, words 7..0.
    le0 = le_pulses;
    push_full();
    pulse(1'b1, 1'b0, 3'd0);
    check("busy_on_start", 32'(bus.busy), 32'h1);
    wait_done(n);
    check("full_latency", 32'(n), 32'(NR*WORD_CYC));
    check("full_done_busy", 32'(bus.busy), 32'h0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'h0);
    check("full_le", 32'(le_pulses - le0), 32'(NR));
    check("full_bits_left", 32'(exp_bits.size()), 32'h0);

    // Single word 3.
    image[3] = 32'hA5A5_0003;
    drive_image();
    le0 = le_pulses; r0 = rises;
    push_word(image[3]);
    pulse(1'b0, 1'b1, 3'd3);
    wait_done(n);
    check("single_latency", 32'(n), 32'(WORD_CYC));
    check("single_rises", 32'(rises - r0), 32'(RW));
    check("single_le", 32'(le_pulses - le0), 32'h1);
    check("single_bits_left", 32'(exp_bits.size()), 32'h0);

    // Out-of-range start_one on a 6-word loader.
    @(negedge clk);
    bus6.start_one = 1'b1; bus6.reg_sel = 3'd7;
    @(posedge clk); #1;
    bus6.start_one = 1'b0;
    $display("start_one reg_sel=7 on 6-word loader, err=%0b busy=%0b", bus6.err, bus6.busy);
    check("err_pulse", 32'(bus6.err), 32'h1);
    check("err_busy", 32'(bus6.busy), 32'h0);
    @(posedge clk); #1;
    check("err_one_cycle", 32'(bus6.err), 32'h0);
    check("err_idle_outputs", {28'h0, bus6.busy, bus6.pll_clk, bus6.writeData, bus6.loadEnable}, 32'h0);

    // Restart and reg_data changes mid-transfer are ignored.
    le0 = le_pulses;
    push_full();
    pulse(1'b1, 1'b0, 3'd0);
    repeat (700) @(posedge clk);
    bus.reg_data = {NR{32'hDEAD_BEEF}};
    pulse(1'b1, 1'b1, 3'd2);
    wait_done(n);
    check("restart_ignored_latency", 32'(n), 32'(NR*WORD_CYC - 701));
    check("restart_le", 32'(le_pulses - le0), 32'(NR));
    check("restart_bits_left", 32'(exp_bits.size()), 32'h0);
    drive_image();

    // Reset during word 5 SHIFT_HIGH; start together with start_one acts as start.
    le0 = le_pulses;
    push_full();
    pulse(1'b1, 1'b1, 3'd3);
    n = 0;
    while (n < 2000 && (le_pulses - le0) < 2) begin @(negedge clk); n++; end
    check("abort_reach_word5", 32'(le_pulses - le0), 32'h2);
    n = 0;
    while (n < 200 && !bus.pll_clk) begin @(negedge clk); n++; end
    check("abort_in_shift_high", 32'(bus.pll_clk), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    $display("reset asserted mid-word-5");
    check("abort_outputs", {26'h0, bus.pll_clk, bus.writeData, bus.loadEnable,
                            bus.busy, bus.done, bus.err}, 32'h0);
    exp_bits.delete();
    d0 = done_cnt; le0 = le_pulses;
    repeat (5) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'h0);
    check("abort_no_le", 32'(le_pulses - le0), 32'h0);
    check("abort_idle_busy", 32'(bus.busy), 32'h0);

    push_full();
    pulse(1'b1, 1'b0, 3'd0);
    wait_done(n);
    check("after_abort_latency", 32'(n), 32'(NR*WORD_CYC));
    check("after_abort_le", 32'(le_pulses - le0), 32'(NR));
    check("after_abort_bits_left", 32'(exp_bits.size()), 32'h0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pll_serial_loader.md
PLL_SERIAL_LOADER -- requirements
Module: pll_serial_loader

Interface
REQ-001 Parameter NUM_REGS, default 8, number of PLL registers in the programming image.
REQ-002 Parameter REG_WIDTH, default 32, bits per register word, shifted MSB first.
REQ-003 Parameter CLK_DIV, default 4, clk cycles per serial-clock half-period (>=1).
REQ-004 Parameter LE_CYCLES, default 8, clk cycles loadEnable is held high per word (>=1).
REQ-005 clk  input  1  system clock; all logic is on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 reg_data  input  NUM_REGS*REG_WIDTH  register image; word k is bits [k*REG_WIDTH +: REG_WIDTH].
REQ-008 start  input  1  one-cycle request to program all words.
REQ-009 start_one  input  1  one-cycle request to program the single word selected by reg_sel.
REQ-010 reg_sel  input  clog2(NUM_REGS), min 1  word index for start_one.
REQ-011 pll_clk  output  1  serial clock to the PLL.
REQ-012 writeData  output  1  serial data to the PLL.
REQ-013 loadEnable  output  1  latch strobe to the PLL.
REQ-014 busy  output  1  high while a transfer is in progress.
REQ-015 done  output  1  one-cycle pulse on transfer completion.
REQ-016 err  output  1  one-cycle pulse when start_one is rejected for reg_sel >= NUM_REGS.

Function
REQ-017 FSM states: IDLE, SHIFT_LOW, SHIFT_HIGH, LATCH, GAP.
REQ-018 In IDLE with start high, the block shall snapshot reg_data, load word NUM_REGS-1, assert busy and enter SHIFT_LOW on the next cycle.
REQ-019 In IDLE with start_one high, start low and reg_sel < NUM_REGS, the block shall snapshot word reg_sel only, as in REQ-018.
REQ-020 start and start_one high together shall be treated as start; both are ignored while busy is high.
REQ-021 start_one with reg_sel >= NUM_REGS shall pulse err one cycle later, stay in IDLE and leave busy low.
REQ-022 SHIFT_LOW: pll_clk low, writeData = current bit, held CLK_DIV cycles, then SHIFT_HIGH.
REQ-023 SHIFT_HIGH: pll_clk high, writeData unchanged, held CLK_DIV cycles; then next bit in SHIFT_LOW, or LATCH after bit 0.
REQ-024 LATCH: pll_clk low, loadEnable high for exactly LE_CYCLES cycles, then GAP.
REQ-025 GAP: all serial outputs low for CLK_DIV cycles; then next lower word index in SHIFT_LOW, or finish if word 0 (or the single word) was sent.
REQ-026 On finish the block shall return to IDLE, drop busy and pulse done in the same cycle.
REQ-027 Per-word duration is 2*CLK_DIV*REG_WIDTH + LE_CYCLES + CLK_DIV cycles; full programming is NUM_REGS times that.
REQ-028 writeData shall only change while pll_clk is low; loadEnable shall never be high while pll_clk is high.
REQ-029 Changes to reg_data during busy shall not affect the transfer in progress.

Reset
REQ-030 On reset_n low, asynchronously: state IDLE; pll_clk, writeData, loadEnable, busy, done and err low; counters cleared.
REQ-031 Reset mid-transfer shall abort without a loadEnable pulse; no done is issued for the aborted transfer.

Configuration
REQ-032 Macro PLL_AUTO_INIT_EN: when defined, the block shall act as if start were pulsed in the first cycle after reset_n deasserts, programming the full image once.
REQ-033 Without PLL_AUTO_INIT_EN, transfers begin only on start or start_one.

Verification
REQ-034 Defaults, reg_data word k = 32'h0000_0000 | k, pulse start -> words 7..0 shifted MSB first, 8 loadEnable pulses of 8 cycles, done after 2144 cycles.
REQ-035 start_one with reg_sel=3, word 3 = 32'hA5A5_0003 -> exactly 32 pll_clk rising edges carrying that pattern, one loadEnable pulse, done after 268 cycles.
REQ-036 NUM_REGS=6, start_one with reg_sel=7 -> err pulse one cycle later, busy and serial outputs stay low.
REQ-037 start, then start and reg_data changes mid-transfer -> second start ignored, shifted data matches the original snapshot.
REQ-038 reset_n low during word 5 SHIFT_HIGH -> all outputs low immediately, no done; a later start programs the full image from word 7.
REQ-039 PLL_AUTO_INIT_EN defined, release reset with no start -> full 8-word sequence and done; undefined -> outputs stay idle.
